// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
   function automatic logic mode_hit(input edge_mode_t mode, input logic rise, input logic fall);
      return (rise & mode[0]) | (fall & mode[1]);
   endfunction

endpackage

// File: rtl/multi_edge_detect_if.sv
// Channel bus of the multi-channel edge detector: raw inputs and controls in, pulses and flags out.
interface multi_edge_detect_if #(
   parameter int NUM_CH = 4
);

   logic [NUM_CH-1:0]                  sig_in;
   logic [edge_pkg::MODE_W*NUM_CH-1:0] mode;
   logic [NUM_CH-1:0]                  clear;
   logic [NUM_CH-1:0]                  edge_pulse;
   logic [NUM_CH-1:0]                  edge_rise;
   logic [NUM_CH-1:0]                  event_flag;
   logic                               any_event;

   modport master (
      output sig_in, mode, clear,
      input  edge_pulse, edge_rise, event_flag, any_event
   );

   modport slave (
      input  sig_in, mode, clear,
      output edge_pulse, edge_rise, event_flag, any_event
   );

endinterface

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser, optional debounce filter, edge detect, sticky flag.
// The debounce filter exists only when EDGE_DEBOUNCE_EN is defined.
module edge_chan
   import edge_pkg::*;
#(
`ifdef EDGE_DEBOUNCE_EN
   parameter int DEBOUNCE_CYCLES = 4,
`endif
   parameter int SYNC_STAGES     = 2
)(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       sig_i,
   input  edge_mode_t mode_i,
   input  logic       clear_i,
   output logic       pulse_o,
   output logic       rise_o,
   output logic       flag_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   lvl;
   logic                   prev_q;
   logic                   rise, fall;
   logic                   pulse_q, pulse_d;
   logic                   rise_q;
   logic                   flag_q, flag_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
   // the synchroniser chain is reset too, so no level captured before reset can create an edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= sig_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lvl_q, lvl_d;

   // The new level is accepted on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (synced != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d = synced;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         lvl_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         lvl_q <= lvl_d;
         cnt_q <= cnt_d;
      end
   end

   assign lvl = lvl_q;
`else
   assign lvl = synced;
`endif

   // prev tracks lvl regardless of mode, so enabling a channel never reports an old change.
   assign rise = lvl & ~prev_q;
   assign fall = ~lvl & prev_q;

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      pulse_d = mode_hit(mode_i, rise, fall);
      flag_d  = (flag_q & ~clear_i) | pulse_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
         rise_q  <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         prev_q  <= lvl;
         pulse_q <= pulse_d;
         rise_q  <= rise;
         flag_q  <= flag_d;
      end
   end

   assign pulse_o = pulse_q;
   assign rise_o  = rise_q;
   assign flag_o  = flag_q;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector top: one edge_chan per channel and the any_event reduction.
// Define EDGE_DEBOUNCE_EN to add a DEBOUNCE_CYCLES stability filter in front of each detector.
module multi_edge_detect
   import edge_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
)(
   input  logic               clk,
   input  logic               n_rst,
   multi_edge_detect_if.slave bus
);

   logic [NUM_CH-1:0] pulse_w;
   logic [NUM_CH-1:0] rise_w;
   logic [NUM_CH-1:0] flag_w;

   if (NUM_CH < 1 || SYNC_STAGES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("multi_edge_detect: NUM_CH, SYNC_STAGES and DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      edge_chan #(
`ifdef EDGE_DEBOUNCE_EN
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`endif
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_chan (
         .clk     (clk),
         .n_rst   (n_rst),
         .sig_i   (bus.sig_in[i]),
         .mode_i  (edge_mode_t'(bus.mode[MODE_W*i +: MODE_W])),
         .clear_i (bus.clear[i]),
         .pulse_o (pulse_w[i]),
         .rise_o  (rise_w[i]),
         .flag_o  (flag_w[i])
      );
   end

   assign bus.edge_pulse = pulse_w;
   assign bus.edge_rise  = rise_w;
   assign bus.event_flag = flag_w;
   assign bus.any_event  = |flag_w;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench for multi_edge_detect: directed vector table plus multi-cycle sequences.
module tb_multi_edge_detect;

   localparam int NUM_CH          = 4;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
`ifdef EDGE_DEBOUNCE_EN
   localparam int PULSE_AT = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
   localparam int HOLD     = DEBOUNCE_CYCLES;
`else
   localparam int PULSE_AT = SYNC_STAGES + 1;
   localparam int HOLD     = 1;
`endif
   localparam int N_RAND = 300;

   logic clk = 1'b0;
   logic n_rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   multi_edge_detect_if #(.NUM_CH(NUM_CH)) bus ();

   multi_edge_detect #(
      .NUM_CH          (NUM_CH),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] sig;
      logic [7:0] mode;
      logic [3:0] clr;
      logic [3:0] pulse;
      logic [3:0] rise;
      logic [3:0] flag;
   } vec_t;

   vec_t       vq[$];
   int         tog_exp[NUM_CH], rise_exp[NUM_CH], pul_got[NUM_CH], rpul_got[NUM_CH];
   logic [3:0] mask;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] sig, input logic [7:0] mode, input logic [3:0] clr,
                      input logic [3:0] pulse, input logic [3:0] rise, input logic [3:0] flag);
      vq.push_back('{sig, mode, clr, pulse, rise, flag});
   endtask

   task automatic drive(input logic [3:0] sig, input logic [7:0] mode, input logic [3:0] clr);
      bus.sig_in = sig;
      bus.mode   = mode;
      bus.clear  = clr;
   endtask

   // Outputs are sampled on the falling edge that follows each rising edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_cycle();
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst = 1'b0;
      drive(4'h0, 8'h00, 4'h0);
      @(negedge clk);
      @(negedge clk);
      check("reset edge_pulse", bus.edge_pulse, 4'h0);
      check("reset edge_rise", bus.edge_rise, 4'h0);
      check("reset event_flag", bus.event_flag, 4'h0);
      check("reset any_event", {3'b000, bus.any_event}, 4'h0);
      n_rst = 1'b1;

`ifndef EDGE_DEBOUNCE_EN
      //   sig    mode   clr    pulse  rise   flag
      add(4'h0, 8'h59, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 8'h59, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 8'h59, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 8'h59, 4'h0, 4'h1, 4'h1, 4'h0);
      add(4'h1, 8'h59, 4'h0, 4'h0, 4'h0, 4'h1);
      add(4'h3, 8'h59, 4'h0, 4'h0, 4'h0, 4'h1);
      add(4'h3, 8'h59, 4'h0, 4'h0, 4'h0, 4'h1);
      add(4'h1, 8'h59, 4'h0, 4'h0, 4'h2, 4'h1);
      add(4'h1, 8'h59, 4'h0, 4'h0, 4'h0, 4'h1);
      add(4'h1, 8'h59, 4'h0, 4'h2, 4'h0, 4'h1);
      add(4'h1, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h3);
      add(4'h3, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h3);
      add(4'h3, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h3);
      add(4'h1, 8'h5D, 4'h0, 4'h2, 4'h2, 4'h3);
      add(4'h1, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h3);
      add(4'h1, 8'h5D, 4'h0, 4'h2, 4'h0, 4'h3);
      add(4'h1, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h3);
      add(4'h5, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h3);
      add(4'h5, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h3);
      add(4'h5, 8'h5D, 4'h0, 4'h4, 4'h4, 4'h3);
      add(4'h5, 8'h5D, 4'h4, 4'h0, 4'h0, 4'h7);
      add(4'h5, 8'h5D, 4'h4, 4'h0, 4'h0, 4'h3);
      add(4'h5, 8'h5D, 4'h3, 4'h0, 4'h0, 4'h0);
      add(4'h5, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h4, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h4, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h4, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h4, 8'h5D, 4'h0, 4'h0, 4'h0, 4'h0);

      foreach (vq[i]) begin
         drive(vq[i].sig, vq[i].mode, vq[i].clr);
         tick();
         check($sformatf("vec%0d edge_pulse", i), bus.edge_pulse, vq[i].pulse);
         check($sformatf("vec%0d edge_rise", i), bus.edge_rise, vq[i].rise);
         check($sformatf("vec%0d event_flag", i), bus.event_flag, vq[i].flag);
         check($sformatf("vec%0d any_event", i), {3'b000, bus.any_event}, {3'b000, |vq[i].flag});
      end
`else
      // 3-cycle glitch is filtered out; a 6-cycle pulse is accepted DEBOUNCE_CYCLES late.
      drive(4'h1, 8'h55, 4'h0);
      for (int t = 1; t <= 15; t++) begin
         if (t == 4) bus.sig_in = 4'h0;
         tick();
         check($sformatf("glitch t%0d edge_pulse", t), bus.edge_pulse, 4'h0);
      end
      drive(4'h1, 8'h55, 4'h0);
      for (int t = 1; t <= 14; t++) begin
         if (t == 7) bus.sig_in = 4'h0;
         tick();
         check($sformatf("debounced t%0d edge_pulse", t), bus.edge_pulse,
               (t == PULSE_AT) ? 4'h1 : 4'h0);
      end
`endif

      // All channels change together in both directions with mode 11.
      drive(4'h0, 8'hFF, 4'h0);
      reset_cycle();
      tick();
      bus.sig_in = 4'hF;
      for (int t = 1; t <= PULSE_AT + 2; t++) begin
         tick();
         check($sformatf("all-rise t%0d edge_pulse", t), bus.edge_pulse,
               (t == PULSE_AT) ? 4'hF : 4'h0);
         if (t == PULSE_AT) check("all-rise edge_rise", bus.edge_rise, 4'hF);
      end
      check("all-rise event_flag", bus.event_flag, 4'hF);
      check("all-rise any_event", {3'b000, bus.any_event}, 4'h1);
      bus.sig_in = 4'h0;
      for (int t = 1; t <= PULSE_AT + 2; t++) begin
         tick();
         check($sformatf("all-fall t%0d edge_pulse", t), bus.edge_pulse,
               (t == PULSE_AT) ? 4'hF : 4'h0);
         if (t == PULSE_AT) check("all-fall edge_rise", bus.edge_rise, 4'h0);
      end

      // Channel 3 changes while off; enabling it later must not report that change.
      drive(4'h8, 8'h3F, 4'h0);
      for (int t = 1; t <= 10; t++) begin
         tick();
         check($sformatf("off t%0d edge_pulse", t), bus.edge_pulse, 4'h0);
      end
      check("off event_flag held", bus.event_flag, 4'hF);
      bus.mode = 8'h7F;
      for (int t = 1; t <= 6; t++) begin
         tick();
         check($sformatf("enabled t%0d edge_pulse", t), bus.edge_pulse, 4'h0);
      end

      // Channel 0 edge in flight when reset hits is discarded; channel 3 high through reset pulses once.
      bus.sig_in = 4'h9;
      tick();
      n_rst = 1'b0;
      bus.sig_in = 4'h8;
      #1;
      check("midreset edge_pulse", bus.edge_pulse, 4'h0);
      check("midreset edge_rise", bus.edge_rise, 4'h0);
      check("midreset event_flag", bus.event_flag, 4'h0);
      check("midreset any_event", {3'b000, bus.any_event}, 4'h0);
      @(negedge clk);
      n_rst = 1'b1;
      for (int t = 1; t <= PULSE_AT + 3; t++) begin
         tick();
         check($sformatf("post-reset t%0d edge_pulse", t), bus.edge_pulse,
               (t == PULSE_AT) ? 4'h8 : 4'h0);
         if (t == PULSE_AT) check("post-reset edge_rise", bus.edge_rise, 4'h8);
      end
      check("post-reset event_flag", bus.event_flag, 4'h8);

      // Random toggling: pulses per channel must equal toggles per channel.
      drive(4'h0, 8'hFF, 4'h0);
      reset_cycle();
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
         tog_exp[c] = 0; rise_exp[c] = 0; pul_got[c] = 0; rpul_got[c] = 0;
      end
      for (int k = 0; k < N_RAND + PULSE_AT + 2; k++) begin
         if (k < N_RAND && (k % HOLD) == 0) begin
            mask = 4'($urandom_range(0, 15));
            for (int c = 0; c < NUM_CH; c++) begin
               if (mask[c]) begin
                  tog_exp[c]++;
                  if (!bus.sig_in[c]) rise_exp[c]++;
               end
            end
            bus.sig_in = bus.sig_in ^ mask;
         end
         tick();
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.edge_pulse[c]) pul_got[c]++;
            if (bus.edge_pulse[c] && bus.edge_rise[c]) rpul_got[c]++;
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         check_int($sformatf("random ch%0d pulse count", c), pul_got[c], tog_exp[c]);
         check_int($sformatf("random ch%0d rise count", c), rpul_got[c], rise_exp[c]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
